mxlsu_burst: RTL and testbench
==============================

// Module: mxlsu_burst
// PURPOSE
//  Clocked successor to the combinational LSU: moves 1..MAX_BURST consecutive bytes between
//  the register bus and the BIU per command, auto-incrementing memory address and register index.
//  Sits between the core control/register file and the BIU; owns the BIU load/store handshake.
// PARAMETERS
//  ADDR_WIDTH    8   BIU address width; base address taken from the low ADDR_WIDTH bits of a register
//  DATA_WIDTH    8   BIU data width (<=8)
//  REGBUS_WIDTH  16  number of 8-bit registers on reg_line; RW=$clog2(REGBUS_WIDTH)
//  MAX_BURST     4   max beats per command (power of 2, >=2); BW=$clog2(MAX_BURST)
// PORTS
//  clk             in   1                clock, all state on rising edge
//  rst_n           in   1                asynchronous, active-low reset
//  biu_rd_addr     out  ADDR_WIDTH       load beat address
//  biu_rdata       in   DATA_WIDTH       load beat data, valid with biu_load_valid
//  biu_load_ready  in   1                BIU accepts load request this cycle
//  biu_load        out  1                load beat request
//  biu_load_valid  in   1                load beat data returned (1-cycle pulse)
//  biu_wr_addr     out  ADDR_WIDTH       store beat address
//  biu_wdata       out  DATA_WIDTH       store beat data
//  biu_store_ready in   1                BIU accepts store request this cycle
//  biu_store       out  1                store beat request
//  biu_store_valid in   1                store beat completed (1-cycle pulse)
//  reg_line        in   REGBUS_WIDTH*8   packed register file snapshot
//  wb_data         out  8                load writeback data, zero-extended from DATA_WIDTH
//  wb_addr         out  RW               load writeback register index
//  wb_en           out  1                load writeback strobe (1 cycle per beat)
//  addr_src/reg_dst in  RW               load: register holding base address / first dest register
//  addr_dst/reg_src in  RW               store: register holding base address / first source register
//  burst_len       in   BW               beats-1 for the command (0 = single beat)
//  load / store    in   1                command strobes, accepted only when matching *_ready=1
//  load_ready      out  1                high only in IDLE
//  store_ready     out  1                high only in IDLE and load=0
//  load_valid      out  1                1-cycle pulse: whole load burst written back
//  store_valid     out  1                1-cycle pulse: whole store burst completed
// BEHAVIOUR
//  Reset: FSM=IDLE; biu_load, biu_store, wb_en, load_valid, store_valid=0; addresses, data, wb_addr,
//   beat counter=0. Reset mid-burst aborts it: no further beats, no valid pulse, no writeback.
//  States: IDLE, LD_REQ, LD_WAIT, ST_REQ, ST_WAIT.
//  IDLE: load=1 -> latch base=reg_line[addr_src][ADDR_WIDTH-1:0], reg_dst, burst_len; beat=0; -> LD_REQ.
//   store=1 & load=0 -> latch base=reg_line[addr_dst], reg_src, burst_len -> ST_REQ. Simultaneous
//   load&store: load wins; store ignored (store_ready=0 that cycle), caller must re-issue.
//  LD_REQ: biu_load=1, biu_rd_addr=base+beat (mod 2^ADDR_WIDTH). Held until cycle with
//   biu_load_ready=1 (accept), then biu_load drops next cycle -> LD_WAIT.
//  LD_WAIT: on biu_load_valid: registered writeback next cycle: wb_en=1, wb_data=biu_rdata,
//   wb_addr=reg_dst+beat (mod REGBUS_WIDTH). If beat==burst_len -> load_valid=1 with the final wb_en, -> IDLE;
//   else beat++ -> LD_REQ. biu_load_valid outside LD_WAIT ignored.
//  ST_REQ: entry cycle captures biu_wdata=reg_line[reg_src+beat mod REGBUS_WIDTH][DATA_WIDTH-1:0],
//   biu_wr_addr=base+beat; both held stable while biu_store=1; accept on biu_store_ready -> ST_WAIT.
//  ST_WAIT: on biu_store_valid: last beat -> store_valid=1 next cycle, -> IDLE; else beat++ -> ST_REQ.
//  Base address is sampled once at command accept; later reg_line changes do not move it.
//  Throughput: one beat per >=2 cycles plus BIU latency; min load latency burst_len+1 round trips.
//  wb_en/load_valid/store_valid are 1-cycle pulses; no command accepted in the cycle a valid pulses.
// TESTING
//  Single load: reg[2]=0x40, addr_src=2, reg_dst=5, burst_len=0, BIU returns 0xA5 -> wb_en once, wb_addr=5, wb_data=0xA5, load_valid 1 cycle.
//  Burst load wrap: reg[0]=0xFE, reg_dst=15, burst_len=3 -> rd_addr 0xFE,0xFF,0x00,0x01; wb_addr 15,0,1,2; one load_valid after 4th.
//  Burst store with ready stalls: reg[1]=0x10, reg_src=3 (0x11..0x14), burst_len=3, ready low 3 cycles/beat -> addr/data stable while stalled, store_valid once.
//  Simultaneous load&store in IDLE -> load executes, store_ready=0, no biu_store activity.
//  rst_n low during LD_WAIT beat 2 -> all outputs 0 asynchronously; after release late biu_load_valid -> no wb_en.
//  Back-to-back: store issued the cycle after load_valid -> accepted, no beat lost or duplicated.

Source files
------------

// File: rtl/mxlsu_burst.sv
// mxlsu_burst
// Burst load/store unit sitting between the core control/register file and the
// bus interface unit (BIU). Each accepted command moves 1..MAX_BURST consecutive
// bytes, auto-incrementing both the memory address and the register index.
// This unit owns the BIU load/store request handshake.
//
// Ports
//   clk, rst_n                       clock (rising edge), async active-low reset
//   biu_rd_addr / biu_load           load beat address and request
//   biu_load_ready                   BIU accepts the load request this cycle
//   biu_rdata / biu_load_valid       returned load beat data (1-cycle pulse)
//   biu_wr_addr / biu_wdata          store beat address and data
//   biu_store                        store beat request
//   biu_store_ready                  BIU accepts the store request this cycle
//   biu_store_valid                  store beat completed (1-cycle pulse)
//   reg_line                         packed snapshot of the 8-bit register file
//   wb_en / wb_addr / wb_data        per-beat load writeback strobe, index, data
//   addr_src / reg_dst               load: base-address register / first dest reg
//   addr_dst / reg_src               store: base-address register / first source reg
//   burst_len                        beats minus one for the command
//   load / store                     command strobes
//   load_ready / store_ready         command acceptance windows
//   load_valid / store_valid         whole-burst completion pulses
module mxlsu_burst #(
    parameter int ADDR_WIDTH   = 8,
    parameter int DATA_WIDTH   = 8,
    parameter int REGBUS_WIDTH = 16,
    parameter int MAX_BURST    = 4,
    localparam int RW = $clog2(REGBUS_WIDTH),
    localparam int BW = $clog2(MAX_BURST)
) (
    input  logic                      clk,
    input  logic                      rst_n,
    output logic [ADDR_WIDTH-1:0]     biu_rd_addr,
    input  logic [DATA_WIDTH-1:0]     biu_rdata,
    input  logic                      biu_load_ready,
    output logic                      biu_load,
    input  logic                      biu_load_valid,
    output logic [ADDR_WIDTH-1:0]     biu_wr_addr,
    output logic [DATA_WIDTH-1:0]     biu_wdata,
    input  logic                      biu_store_ready,
    output logic                      biu_store,
    input  logic                      biu_store_valid,
    input  logic [REGBUS_WIDTH*8-1:0] reg_line,
    output logic [7:0]                wb_data,
    output logic [RW-1:0]             wb_addr,
    output logic                      wb_en,
    input  logic [RW-1:0]             addr_src,
    input  logic [RW-1:0]             reg_dst,
    input  logic [RW-1:0]             addr_dst,
    input  logic [RW-1:0]             reg_src,
    input  logic [BW-1:0]             burst_len,
    input  logic                      load,
    input  logic                      store,
    output logic                      load_ready,
    output logic                      store_ready,
    output logic                      load_valid,
    output logic                      store_valid
);

    typedef enum logic [2:0] {
        IDLE,
        LD_REQ,
        LD_WAIT,
        ST_REQ,
        ST_WAIT
    } state_t;

    state_t                  state_q, state_d;
    logic [ADDR_WIDTH-1:0]   base_q, base_d;
    logic [RW-1:0]           regIdx_q, regIdx_d;
    logic [BW-1:0]           len_q, len_d;
    logic [BW-1:0]           beat_q, beat_d;
    logic [ADDR_WIDTH-1:0]   rdAddr_q, rdAddr_d;
    logic [ADDR_WIDTH-1:0]   wrAddr_q, wrAddr_d;
    logic [DATA_WIDTH-1:0]   wdata_q, wdata_d;
    logic [7:0]              wbData_q, wbData_d;
    logic [RW-1:0]           wbAddr_q, wbAddr_d;
    logic                    wbEn_q, wbEn_d;
    logic                    loadValid_q, loadValid_d;
    logic                    storeValid_q, storeValid_d;

    logic [BW-1:0]           beatNext;
    logic [RW-1:0]           stIdxNext;

    assign beatNext  = beat_q + BW'(1);
    // Register index wraps modulo the register file size.
    assign stIdxNext = regIdx_q + RW'(beatNext);

    // Commands are refused while a completion pulse is out, so the caller sees
    // the pulse before the unit can be reused. Load wins over a same-cycle store.
    assign load_ready  = (state_q == IDLE) && !loadValid_q && !storeValid_q;
    assign store_ready = load_ready && !load;

    assign biu_load    = (state_q == LD_REQ);
    assign biu_store   = (state_q == ST_REQ);
    assign biu_rd_addr = rdAddr_q;
    assign biu_wr_addr = wrAddr_q;
    assign biu_wdata   = wdata_q;
    assign wb_en       = wbEn_q;
    assign wb_data     = wbData_q;
    assign wb_addr     = wbAddr_q;
    assign load_valid  = loadValid_q;
    assign store_valid = storeValid_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            base_q       <= '0;
            regIdx_q     <= '0;
            len_q        <= '0;
            beat_q       <= '0;
            rdAddr_q     <= '0;
            wrAddr_q     <= '0;
            wdata_q      <= '0;
            wbData_q     <= '0;
            wbAddr_q     <= '0;
            wbEn_q       <= 1'b0;
            loadValid_q  <= 1'b0;
            storeValid_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            base_q       <= base_d;
            regIdx_q     <= regIdx_d;
            len_q        <= len_d;
            beat_q       <= beat_d;
            rdAddr_q     <= rdAddr_d;
            wrAddr_q     <= wrAddr_d;
            wdata_q      <= wdata_d;
            wbData_q     <= wbData_d;
            wbAddr_q     <= wbAddr_d;
            wbEn_q       <= wbEn_d;
            loadValid_q  <= loadValid_d;
            storeValid_q <= storeValid_d;
        end
    end

    // Beat addresses and store data are registered on the transition into a
    // request state, so they are already valid and stay frozen for as long as
    // the BIU stalls the request.
    always_comb begin
        state_d      = state_q;
        base_d       = base_q;
        regIdx_d     = regIdx_q;
        len_d        = len_q;
        beat_d       = beat_q;
        rdAddr_d     = rdAddr_q;
        wrAddr_d     = wrAddr_q;
        wdata_d      = wdata_q;
        wbData_d     = wbData_q;
        wbAddr_d     = wbAddr_q;
        wbEn_d       = 1'b0;
        loadValid_d  = 1'b0;
        storeValid_d = 1'b0;

        case (state_q)
            IDLE: begin
                if (load_ready && load) begin
                    base_d   = reg_line[{addr_src, 3'b000} +: ADDR_WIDTH];
                    rdAddr_d = reg_line[{addr_src, 3'b000} +: ADDR_WIDTH];
                    regIdx_d = reg_dst;
                    len_d    = burst_len;
                    beat_d   = '0;
                    state_d  = LD_REQ;
                end else if (store_ready && store) begin
                    base_d   = reg_line[{addr_dst, 3'b000} +: ADDR_WIDTH];
                    wrAddr_d = reg_line[{addr_dst, 3'b000} +: ADDR_WIDTH];
                    wdata_d  = reg_line[{reg_src, 3'b000} +: DATA_WIDTH];
                    regIdx_d = reg_src;
                    len_d    = burst_len;
                    beat_d   = '0;
                    state_d  = ST_REQ;
                end
            end
            LD_REQ: begin
                if (biu_load_ready) begin
                    state_d = LD_WAIT;
                end
            end
            LD_WAIT: begin
                if (biu_load_valid) begin
                    wbEn_d                   = 1'b1;
                    wbData_d                 = '0;
                    wbData_d[DATA_WIDTH-1:0] = biu_rdata;
                    wbAddr_d                 = regIdx_q + RW'(beat_q);
                    if (beat_q == len_q) begin
                        loadValid_d = 1'b1;
                        state_d     = IDLE;
                    end else begin
                        beat_d   = beatNext;
                        rdAddr_d = base_q + ADDR_WIDTH'(beatNext);
                        state_d  = LD_REQ;
                    end
                end
            end
            ST_REQ: begin
                if (biu_store_ready) begin
                    state_d = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (biu_store_valid) begin
                    if (beat_q == len_q) begin
                        storeValid_d = 1'b1;
                        state_d      = IDLE;
                    end else begin
                        beat_d   = beatNext;
                        wrAddr_d = base_q + ADDR_WIDTH'(beatNext);
                        wdata_d  = reg_line[{stIdxNext, 3'b000} +: DATA_WIDTH];
                        state_d  = ST_REQ;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_mxlsu_burst.sv
// tb_mxlsu_burst
// Self-checking bench for mxlsu_burst. A behavioural BIU with programmable
// ready stalls and response latency serves a small memory; expected BIU
// addresses, store beats and writebacks are queued when a command is issued
// and popped as the unit produces them.
module tb_mxlsu_burst;

    localparam int AW = 8;
    localparam int DW = 8;
    localparam int NREG = 16;
    localparam int MB = 4;

    logic           clk;
    logic           rst_n;
    logic [AW-1:0]  biu_rd_addr;
    logic [DW-1:0]  biu_rdata;
    logic           biu_load_ready;
    logic           biu_load;
    logic           biu_load_valid;
    logic [AW-1:0]  biu_wr_addr;
    logic [DW-1:0]  biu_wdata;
    logic           biu_store_ready;
    logic           biu_store;
    logic           biu_store_valid;
    logic [NREG*8-1:0] reg_line;
    logic [7:0]     wb_data;
    logic [3:0]     wb_addr;
    logic           wb_en;
    logic [3:0]     addr_src;
    logic [3:0]     reg_dst;
    logic [3:0]     addr_dst;
    logic [3:0]     reg_src;
    logic [1:0]     burst_len;
    logic           load;
    logic           store;
    logic           load_ready;
    logic           store_ready;
    logic           load_valid;
    logic           store_valid;

    mxlsu_burst #(
        .ADDR_WIDTH  (AW),
        .DATA_WIDTH  (DW),
        .REGBUS_WIDTH(NREG),
        .MAX_BURST   (MB)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .biu_rd_addr    (biu_rd_addr),
        .biu_rdata      (biu_rdata),
        .biu_load_ready (biu_load_ready),
        .biu_load       (biu_load),
        .biu_load_valid (biu_load_valid),
        .biu_wr_addr    (biu_wr_addr),
        .biu_wdata      (biu_wdata),
        .biu_store_ready(biu_store_ready),
        .biu_store      (biu_store),
        .biu_store_valid(biu_store_valid),
        .reg_line       (reg_line),
        .wb_data        (wb_data),
        .wb_addr        (wb_addr),
        .wb_en          (wb_en),
        .addr_src       (addr_src),
        .reg_dst        (reg_dst),
        .addr_dst       (addr_dst),
        .reg_src        (reg_src),
        .burst_len      (burst_len),
        .load           (load),
        .store          (store),
        .load_ready     (load_ready),
        .store_ready    (store_ready),
        .load_valid     (load_valid),
        .store_valid    (store_valid)
    );

    typedef struct packed {
        logic [7:0] addr;
        logic [7:0] data;
    } stExp_t;

    typedef struct packed {
        logic [3:0] addr;
        logic [7:0] data;
        logic       last;
    } wbExp_t;

    logic [7:0] expRd[$];
    stExp_t     expSt[$];
    wbExp_t     expWb[$];

    logic [7:0] mem [256];
    logic [7:0] regFile [16];

    int checks = 0;
    int errors = 0;
    int expLv = 0;
    int expSv = 0;
    int lvCnt = 0;
    int svCnt = 0;
    int wbCnt = 0;
    int rdAccCnt = 0;
    int cyc = 0;
    int lvCycle = -10;
    int issueCycle = 0;

    int ldStallN = 0;
    int stStallN = 0;
    int ldLat = 0;
    int stLat = 0;
    int ldStall = 0;
    int stStall = 0;
    int ldCnt = 0;
    int stCnt = 0;
    bit ldAcc = 1'b0;
    bit stAcc = 1'b0;
    bit stHeld = 1'b0;
    bit injectLv = 1'b0;
    logic [7:0] ldAddr = '0;
    logic [7:0] heldAddr = '0;
    logic [7:0] heldData = '0;

    // Free-running clock, 10 time units per cycle.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Every comparison in the bench goes through here.
    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
        end
    endtask

    // Keeps the bench register model and the packed bus in step.
    task automatic setReg(input logic [3:0] idx, input logic [7:0] v);
        regFile[idx] = v;
        reg_line[{idx, 3'b000} +: 8] = v;
    endtask

    // Behavioural BIU plus output monitor. Responses are driven just after the
    // rising edge; handshakes and DUT outputs are sampled on the falling edge,
    // when everything the next rising edge will see is settled.
    initial begin
        wbExp_t e;
        stExp_t s;
        biu_load_ready  = 1'b0;
        biu_store_ready = 1'b0;
        biu_load_valid  = 1'b0;
        biu_store_valid = 1'b0;
        biu_rdata       = '0;
        forever begin
            @(posedge clk);
            #1;
            cyc++;
            biu_load_valid  = 1'b0;
            biu_store_valid = 1'b0;
            if (ldAcc) begin
                ldAcc = 1'b0;
                ldCnt = ldLat + 1;
            end
            if (ldCnt > 0) begin
                ldCnt--;
                if (ldCnt == 0) begin
                    biu_load_valid = 1'b1;
                    biu_rdata      = mem[ldAddr];
                end
            end
            if (injectLv) begin
                injectLv       = 1'b0;
                biu_load_valid = 1'b1;
                biu_rdata      = 8'h5A;
            end
            if (stAcc) begin
                stAcc = 1'b0;
                stCnt = stLat + 1;
            end
            if (stCnt > 0) begin
                stCnt--;
                if (stCnt == 0) begin
                    biu_store_valid = 1'b1;
                end
            end
            if (biu_load && ldStall >= ldStallN) begin
                biu_load_ready = 1'b1;
            end else begin
                biu_load_ready = 1'b0;
                if (biu_load) ldStall++;
            end
            if (biu_store && stStall >= stStallN) begin
                biu_store_ready = 1'b1;
            end else begin
                biu_store_ready = 1'b0;
                if (biu_store) stStall++;
            end

            @(negedge clk);
            if (biu_load && biu_load_ready) begin
                rdAccCnt++;
                if (expRd.size() == 0) begin
                    checkOutput("rd_no_expect", 32'(expRd.size()), 32'd1);
                end else begin
                    checkOutput("rd_addr", 32'(biu_rd_addr), 32'(expRd.pop_front()));
                end
                ldAcc   = 1'b1;
                ldAddr  = biu_rd_addr;
                ldStall = 0;
            end
            if (biu_store) begin
                if (stHeld) begin
                    checkOutput("wr_addr_stable", 32'(biu_wr_addr), 32'(heldAddr));
                    checkOutput("wdata_stable", 32'(biu_wdata), 32'(heldData));
                end
                if (biu_store_ready) begin
                    if (expSt.size() == 0) begin
                        checkOutput("st_no_expect", 32'(expSt.size()), 32'd1);
                    end else begin
                        s = expSt.pop_front();
                        checkOutput("wr_addr", 32'(biu_wr_addr), 32'(s.addr));
                        checkOutput("wdata", 32'(biu_wdata), 32'(s.data));
                    end
                    stAcc   = 1'b1;
                    stHeld  = 1'b0;
                    stStall = 0;
                end else begin
                    stHeld   = 1'b1;
                    heldAddr = biu_wr_addr;
                    heldData = biu_wdata;
                end
            end else begin
                stHeld = 1'b0;
            end
            if (wb_en) begin
                wbCnt++;
                if (expWb.size() == 0) begin
                    checkOutput("wb_no_expect", 32'(expWb.size()), 32'd1);
                end else begin
                    e = expWb.pop_front();
                    checkOutput("wb_addr", 32'(wb_addr), 32'(e.addr));
                    checkOutput("wb_data", 32'(wb_data), 32'(e.data));
                    checkOutput("load_valid_with_last", 32'(load_valid), 32'(e.last));
                end
            end else if (load_valid) begin
                checkOutput("load_valid_alone", 32'(load_valid), 32'd0);
            end
            if (load_valid) begin
                lvCnt++;
                lvCycle = cyc;
            end
            if (store_valid) svCnt++;
        end
    end

    // Waits for the relevant ready, drives one command for a single cycle and
    // queues every beat the command should produce. With alsoStore set, a
    // store strobe is raised alongside the load and must be refused.
    task automatic applyStimulus(input bit isLoad, input bit alsoStore, input logic [3:0] baseReg,
                                 input logic [3:0] dataReg, input logic [1:0] len);
        int waitCnt = 0;
        logic [7:0] base;
        logic [7:0] a;
        logic [3:0] r;
        wbExp_t w;
        stExp_t s;
        while (!(isLoad ? load_ready : store_ready) && waitCnt < 200) begin
            @(posedge clk);
            #2;
            waitCnt++;
        end
        checkOutput(isLoad ? "ld_ready_wait" : "st_ready_wait", 32'(waitCnt < 200), 32'd1);
        issueCycle = cyc;
        base = regFile[baseReg];
        burst_len = len;
        if (isLoad) begin
            load     = 1'b1;
            addr_src = baseReg;
            reg_dst  = dataReg;
        end else begin
            store    = 1'b1;
            addr_dst = baseReg;
            reg_src  = dataReg;
        end
        if (alsoStore) begin
            store    = 1'b1;
            addr_dst = 4'd1;
            reg_src  = 4'd3;
            #1;
            checkOutput("store_ready_collision", 32'(store_ready), 32'd0);
        end
        for (int i = 0; i <= int'(len); i++) begin
            a = base + 8'(i);
            r = dataReg + 4'(i);
            if (isLoad) begin
                expRd.push_back(a);
                w.addr = r;
                w.data = mem[a];
                w.last = (i == int'(len));
                expWb.push_back(w);
            end else begin
                s.addr = a;
                s.data = regFile[r];
                expSt.push_back(s);
            end
        end
        if (isLoad) expLv++;
        else expSv++;
        @(posedge clk);
        #2;
        load  = 1'b0;
        store = 1'b0;
    endtask

    // Waits, bounded, until every queued expectation has been consumed.
    task automatic waitIdle(input string tag);
        int n = 0;
        while ((expRd.size() + expWb.size() + expSt.size() != 0 || lvCnt != expLv || svCnt != expSv) && n < 400) begin
            @(posedge clk);
            #2;
            n++;
        end
        checkOutput({tag, "_outstanding"}, 32'(expRd.size() + expWb.size() + expSt.size()), 32'd0);
        checkOutput({tag, "_load_valid_cnt"}, 32'(lvCnt), 32'(expLv));
        checkOutput({tag, "_store_valid_cnt"}, 32'(svCnt), 32'(expSv));
        repeat (2) @(posedge clk);
        #2;
    endtask

    initial begin
        int startAcc;
        int wbBefore;
        int lvBefore;
        int n;

        // Idle inputs, known memory and register contents.
        rst_n     = 1'b0;
        load      = 1'b0;
        store     = 1'b0;
        addr_src  = '0;
        reg_dst   = '0;
        addr_dst  = '0;
        reg_src   = '0;
        burst_len = '0;
        reg_line  = '0;
        for (int i = 0; i < 256; i++) mem[i] = 8'(i ^ 8'h3C);
        for (int i = 0; i < 16; i++) setReg(4'(i), 8'(8'hC0 + i));

        // Reset state.
        repeat (2) @(posedge clk);
        #2;
        checkOutput("rst_biu_load", 32'(biu_load), 32'd0);
        checkOutput("rst_biu_store", 32'(biu_store), 32'd0);
        checkOutput("rst_wb_en", 32'(wb_en), 32'd0);
        checkOutput("rst_load_valid", 32'(load_valid), 32'd0);
        checkOutput("rst_store_valid", 32'(store_valid), 32'd0);
        checkOutput("rst_rd_addr", 32'(biu_rd_addr), 32'd0);
        checkOutput("rst_wr_addr", 32'(biu_wr_addr), 32'd0);
        checkOutput("rst_wdata", 32'(biu_wdata), 32'd0);
        checkOutput("rst_wb_addr", 32'(wb_addr), 32'd0);
        checkOutput("rst_wb_data", 32'(wb_data), 32'd0);
        rst_n = 1'b1;
        @(posedge clk);
        #2;
        checkOutput("idle_load_ready", 32'(load_ready), 32'd1);
        checkOutput("idle_store_ready", 32'(store_ready), 32'd1);

        // Single-beat load.
        setReg(4'd2, 8'h40);
        mem[8'h40] = 8'hA5;
        applyStimulus(1'b1, 1'b0, 4'd2, 4'd5, 2'd0);
        waitIdle("single_load");

        // Four-beat load wrapping both the memory address and the register index.
        ldStallN = 1;
        ldLat    = 2;
        setReg(4'd0, 8'hFE);
        mem[8'hFE] = 8'h01;
        mem[8'hFF] = 8'h02;
        mem[8'h00] = 8'h03;
        mem[8'h01] = 8'h04;
        applyStimulus(1'b1, 1'b0, 4'd0, 4'd15, 2'd3);
        waitIdle("burst_load_wrap");

        // Four-beat store against a BIU that holds ready low for three cycles per beat.
        stStallN = 3;
        stLat    = 1;
        setReg(4'd1, 8'h10);
        setReg(4'd3, 8'h11);
        setReg(4'd4, 8'h12);
        setReg(4'd5, 8'h13);
        setReg(4'd6, 8'h14);
        applyStimulus(1'b0, 1'b0, 4'd1, 4'd3, 2'd3);
        waitIdle("burst_store_stall");

        // Load and store raised together: only the load may run.
        ldStallN = 0;
        ldLat    = 0;
        stStallN = 0;
        mem[8'h40] = 8'h77;
        applyStimulus(1'b1, 1'b1, 4'd2, 4'd0, 2'd0);
        waitIdle("collision");

        // Reset while waiting on the third beat of a load burst.
        ldLat = 5;
        setReg(4'd7, 8'h80);
        startAcc = rdAccCnt;
        applyStimulus(1'b1, 1'b0, 4'd7, 4'd8, 2'd3);
        n = 0;
        while (rdAccCnt < startAcc + 3 && n < 200) begin
            @(posedge clk);
            #2;
            n++;
        end
        checkOutput("rst_reached_beat2", 32'(rdAccCnt - startAcc), 32'd3);
        rst_n = 1'b0;
        #1;
        checkOutput("async_rst_biu_load", 32'(biu_load), 32'd0);
        checkOutput("async_rst_wb_en", 32'(wb_en), 32'd0);
        checkOutput("async_rst_load_valid", 32'(load_valid), 32'd0);
        checkOutput("async_rst_rd_addr", 32'(biu_rd_addr), 32'd0);
        checkOutput("async_rst_wb_addr", 32'(wb_addr), 32'd0);
        checkOutput("async_rst_wb_data", 32'(wb_data), 32'd0);
        expRd.delete();
        expWb.delete();
        expLv--;
        ldCnt = 0;
        ldAcc = 1'b0;
        @(posedge clk);
        #2;
        rst_n    = 1'b1;
        wbBefore = wbCnt;
        lvBefore = lvCnt;
        injectLv = 1'b1;
        repeat (8) @(posedge clk);
        #2;
        checkOutput("rst_late_valid_no_wb", 32'(wbCnt - wbBefore), 32'd0);
        checkOutput("rst_late_valid_no_lv", 32'(lvCnt - lvBefore), 32'd0);
        checkOutput("rst_back_to_idle", 32'(load_ready), 32'd1);
        waitIdle("reset_abort");

        // Store issued the first cycle the unit is ready again after load_valid.
        ldLat = 1;
        stLat = 1;
        mem[8'h40] = 8'h9E;
        mem[8'h41] = 8'h9F;
        setReg(4'd3, 8'h21);
        setReg(4'd4, 8'h22);
        applyStimulus(1'b1, 1'b0, 4'd2, 4'd10, 2'd1);
        applyStimulus(1'b0, 1'b0, 4'd1, 4'd3, 2'd1);
        waitIdle("back_to_back");
        checkOutput("b2b_issue_gap", 32'(issueCycle - lvCycle), 32'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
